// File: rtl/npu_isa_pkg.sv
// Shared control-unit ISA definitions: op codes, command codes, error codes and field widths.
// The instruction decoder imports this same package.
package npu_isa_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_MOVE  = 2'd2,
        OP_CTRL  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        CMD_LOAD  = 3'd0,
        CMD_STORE = 3'd1,
        CMD_MOVE  = 3'd2,
        CMD_FETCH = 3'd3,
        CMD_EXEC  = 3'd4
    } cmd_op_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_OP     = 3'd1,
        ERR_ZERO_LINES = 3'd2,
        ERR_ALIGN      = 3'd3,
        ERR_RANGE      = 3'd4
    } err_code_t;

    localparam int unsigned LS_RF_W   = 9;
    localparam int unsigned LS_GRAN_W = 13;
    localparam int unsigned MV_ADDR_W = 10;
    localparam int unsigned GROUP_W   = 5;
    localparam int unsigned SUB_W     = 4;
    localparam int unsigned FETCH_W   = 24;
    localparam int unsigned LINES_W   = 8;
    localparam int unsigned LINE_MAX  = 255;

    // Fields of the word currently being emitted; only the ones the op needs are meaningful.
    typedef struct packed {
        cmd_op_t              op;
        logic [LS_RF_W-1:0]   rf;
        logic [LS_GRAN_W-1:0] gran;
        logic [MV_ADDR_W-1:0] src;
        logic [MV_ADDR_W-1:0] dst;
        logic                 src_frz;
        logic                 dst_frz;
        logic [GROUP_W-1:0]   group;
        logic [SUB_W-1:0]     sub;
        logic [FETCH_W-1:0]   fetch;
    } inst_fields_t;

endpackage

// File: rtl/inst_field_pack.sv
// Packs one instruction word from the current fields and the chunk line count.
// Purely combinational; illegal ops produce an all-zero word.
module inst_field_pack
    import npu_isa_pkg::*;
(
    input  inst_fields_t       fields_i,
    input  logic [LINES_W-1:0] lines_i,
    output logic [31:0]        word_o
);

    always_comb begin
        case (fields_i.op)
            CMD_LOAD:  word_o = {OP_LOAD, fields_i.rf, fields_i.gran, lines_i};
            CMD_STORE: word_o = {OP_STORE, fields_i.rf, fields_i.gran, lines_i};
            CMD_MOVE:  word_o = {OP_MOVE, fields_i.src, fields_i.dst,
                                 fields_i.src_frz, fields_i.dst_frz, lines_i};
            CMD_FETCH: word_o = {OP_CTRL, 1'b0, fields_i.group, fields_i.fetch};
            CMD_EXEC:  word_o = {OP_CTRL, 1'b1, fields_i.group, fields_i.sub, 20'b0};
            default:   word_o = '0;
        endcase
    end

endmodule

// File: rtl/inst_encode.sv
// Command-to-instruction encoder: validates NPU commands and emits ISA words,
// splitting long load/store/move transfers into chunks of at most LINE_MAX lines.
module inst_encode
    import npu_isa_pkg::*;
#(
    parameter int unsigned RF_ADDR_W               = 10,
    parameter logic [14:0] SDRAM_OFFSET            = 15'h1000,
    parameter int unsigned SDRAM_GRANULES_PER_LINE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [RF_ADDR_W-1:0] cmd_rf_addr,
    input  logic [31:0]          cmd_sdram_addr,
    input  logic [RF_ADDR_W-1:0] cmd_src_addr,
    input  logic [RF_ADDR_W-1:0] cmd_dst_addr,
    input  logic                 cmd_src_freeze,
    input  logic                 cmd_dst_freeze,
    input  logic [15:0]          cmd_line_num,
    input  logic [4:0]           cmd_eu_group,
    input  logic [3:0]           cmd_eu_sub,
    input  logic [31:0]          cmd_fetch_addr,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst_data,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic                 busy,
    output logic [31:0]          inst_count
);

    localparam logic [0:0]  S_IDLE      = 1'b0;
    localparam logic [0:0]  S_EMIT      = 1'b1;
    localparam int unsigned GPL         = SDRAM_GRANULES_PER_LINE;
    localparam logic [31:0] LS_RF_LIMIT = 32'd512;
    localparam logic [31:0] GRAN_LIMIT  = 32'd8192;
    localparam logic [31:0] MV_LIMIT    = 32'd1 << RF_ADDR_W;

    logic [0:0]         state_q, state_d;
    inst_fields_t       fld_q, fld_d, cmd_fld, adv_fld, pack_fld;
    logic [LINES_W-1:0] chunk_q, chunk_d, first_chunk, next_chunk, pack_lines;
    logic [15:0]        rem_q, rem_d, first_rem;
    logic [31:0]        data_q, data_d, count_q, count_d, pack_word;
    logic               err_valid_q, err_valid_d;
    err_code_t          err_code_q, err_code_d, chk_err;
    logic               is_ls, is_move, is_fetch, is_xfer;
    logic               bad_op, zero_lines, bad_align, bad_range;
    logic [31:0]        rf_end, gran_end, src_end, dst_end;

    // Command checks; the end-address sums are 32 bits wide so they never wrap.
    always_comb begin
        is_ls      = (cmd_op == CMD_LOAD) || (cmd_op == CMD_STORE);
        is_move    = (cmd_op == CMD_MOVE);
        is_fetch   = (cmd_op == CMD_FETCH);
        is_xfer    = is_ls || is_move;
        rf_end     = 32'(cmd_rf_addr) + 32'(cmd_line_num);
        gran_end   = 32'(cmd_sdram_addr[16:4]) + 32'(cmd_line_num) * GPL;
        src_end    = 32'(cmd_src_addr) + 32'(cmd_line_num);
        dst_end    = 32'(cmd_dst_addr) + 32'(cmd_line_num);
        bad_op     = cmd_op > 3'd4;
        zero_lines = is_xfer && (cmd_line_num == 16'd0);
        bad_align  = (is_ls && (cmd_sdram_addr[3:0] != 4'd0))
                  || (is_fetch && (cmd_fetch_addr[3:0] != 4'd0));
        bad_range  = (is_ls && ((cmd_sdram_addr[31:17] != SDRAM_OFFSET)
                                || (rf_end > LS_RF_LIMIT) || (gran_end > GRAN_LIMIT)))
                  || (is_move && ((src_end > MV_LIMIT) || (dst_end > MV_LIMIT)))
                  || (is_fetch && (cmd_fetch_addr[31:28] != 4'd0));
        if (bad_op)          chk_err = ERR_BAD_OP;
        else if (zero_lines) chk_err = ERR_ZERO_LINES;
        else if (bad_align)  chk_err = ERR_ALIGN;
        else if (bad_range)  chk_err = ERR_RANGE;
        else                 chk_err = ERR_NONE;
    end

    always_comb begin
        cmd_fld.op      = cmd_op_t'(cmd_op);
        cmd_fld.rf      = cmd_rf_addr[LS_RF_W-1:0];
        cmd_fld.gran    = cmd_sdram_addr[16:4];
        cmd_fld.src     = MV_ADDR_W'(cmd_src_addr);
        cmd_fld.dst     = MV_ADDR_W'(cmd_dst_addr);
        cmd_fld.src_frz = cmd_src_freeze;
        cmd_fld.dst_frz = cmd_dst_freeze;
        cmd_fld.group   = cmd_eu_group;
        cmd_fld.sub     = cmd_eu_sub;
        cmd_fld.fetch   = cmd_fetch_addr[27:4];

        first_chunk = !is_xfer ? '0
                    : (cmd_line_num > 16'(LINE_MAX)) ? LINES_W'(LINE_MAX) : cmd_line_num[7:0];
        first_rem   = is_xfer ? (cmd_line_num - 16'(first_chunk)) : 16'd0;

        adv_fld      = fld_q;
        adv_fld.rf   = fld_q.rf + LS_RF_W'(chunk_q);
        adv_fld.gran = LS_GRAN_W'(32'(fld_q.gran) + 32'(chunk_q) * GPL);
        adv_fld.src  = fld_q.src + MV_ADDR_W'(chunk_q);
        adv_fld.dst  = fld_q.dst + MV_ADDR_W'(chunk_q);
        next_chunk   = (rem_q > 16'(LINE_MAX)) ? LINES_W'(LINE_MAX) : rem_q[7:0];

        // IDLE packs the incoming command, EMIT packs the following chunk.
        pack_fld   = (state_q == S_IDLE) ? cmd_fld : adv_fld;
        pack_lines = (state_q == S_IDLE) ? first_chunk : next_chunk;
    end

    inst_field_pack u_pack (
        .fields_i (pack_fld),
        .lines_i  (pack_lines),
        .word_o   (pack_word)
    );

    // NOTE: every _d gets its hold value first so no branch can infer a latch.
    always_comb begin
        state_d     = state_q;
        fld_d       = fld_q;
        chunk_d     = chunk_q;
        rem_d       = rem_q;
        data_d      = data_q;
        count_d     = count_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (chk_err != ERR_NONE) begin
                        err_valid_d = 1'b1;
                        err_code_d  = chk_err;
                    end else begin
                        state_d = S_EMIT;
                        fld_d   = cmd_fld;
                        chunk_d = first_chunk;
                        rem_d   = first_rem;
                        data_d  = pack_word;
                    end
                end
            end
            default: begin
                if (inst_ready) begin
                    count_d = count_q + 32'd1;
                    if (rem_q == 16'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        fld_d   = adv_fld;
                        chunk_d = next_chunk;
                        rem_d   = rem_q - 16'(next_chunk);
                        data_d  = pack_word;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers take non-blocking assignments; the comb logic above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fld_q       <= '0;
            chunk_q     <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            count_q     <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            fld_q       <= fld_d;
            chunk_q     <= chunk_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            count_q     <= count_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign inst_valid = (state_q == S_EMIT);
    assign busy       = (state_q == S_EMIT);
    assign inst_data  = data_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign inst_count = count_q;

endmodule

// File: tb/tb_inst_encode.sv
// Self-checking bench for inst_encode: directed scenarios plus randomized commands
// compared against a chunk-by-chunk reference encoder and a word scoreboard.
module tb_inst_encode;

    localparam int unsigned GPL = 1;

    typedef struct {
        int unsigned op, rf, sdram, src, dst, sf, df, lines, group, sub, fetch;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [9:0]  cmd_rf_addr = '0, cmd_src_addr = '0, cmd_dst_addr = '0;
    logic [31:0] cmd_sdram_addr = '0, cmd_fetch_addr = '0;
    logic        cmd_src_freeze = 1'b0, cmd_dst_freeze = 1'b0;
    logic [15:0] cmd_line_num = '0;
    logic [4:0]  cmd_eu_group = '0;
    logic [3:0]  cmd_eu_sub = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        busy;
    logic [31:0] inst_count;

    int total = 0;
    int bad   = 0;

    inst_encode dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_rf_addr    (cmd_rf_addr),
        .cmd_sdram_addr (cmd_sdram_addr),
        .cmd_src_addr   (cmd_src_addr),
        .cmd_dst_addr   (cmd_dst_addr),
        .cmd_src_freeze (cmd_src_freeze),
        .cmd_dst_freeze (cmd_dst_freeze),
        .cmd_line_num   (cmd_line_num),
        .cmd_eu_group   (cmd_eu_group),
        .cmd_eu_sub     (cmd_eu_sub),
        .cmd_fetch_addr (cmd_fetch_addr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .busy           (busy),
        .inst_count     (inst_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic cmd_t mk(int unsigned op, int unsigned rf, int unsigned sdram,
                                int unsigned src, int unsigned dst, int unsigned sf,
                                int unsigned df, int unsigned lines, int unsigned group,
                                int unsigned sub, int unsigned fetch);
        cmd_t c;
        c.op = op; c.rf = rf; c.sdram = sdram; c.src = src; c.dst = dst; c.sf = sf;
        c.df = df; c.lines = lines; c.group = group; c.sub = sub; c.fetch = fetch;
        return c;
    endfunction

    function automatic int unsigned ref_err(cmd_t c);
        bit ls;
        ls = (c.op <= 1);
        if (c.op > 4) return 1;
        if (c.op <= 2 && c.lines == 0) return 2;
        if (ls && (c.sdram % 16) != 0) return 3;
        if (c.op == 3 && (c.fetch % 16) != 0) return 3;
        if (ls && ((c.sdram >> 17) != 32'h1000 || c.rf + c.lines > 512
                   || ((c.sdram >> 4) % 8192) + c.lines * GPL > 8192)) return 4;
        if (c.op == 2 && (c.src + c.lines > 1024 || c.dst + c.lines > 1024)) return 4;
        if (c.op == 3 && (c.fetch >> 28) != 0) return 4;
        return 0;
    endfunction

    function automatic int unsigned ref_nwords(cmd_t c);
        return (c.op <= 2) ? (c.lines + 254) / 255 : 1;
    endfunction

    // k-th word of a legal command: chunk k starts k*255 lines into the transfer.
    function automatic logic [31:0] ref_word(cmd_t c, int unsigned k);
        int unsigned off, ch;
        off = k * 255;
        ch  = (c.lines - off > 255) ? 255 : c.lines - off;
        case (c.op)
            0, 1:    return (c.op << 30) | (((c.rf + off) % 512) << 21)
                            | (((((c.sdram >> 4) % 8192) + off * GPL) % 8192) << 8) | ch;
            2:       return (32'd2 << 30) | (((c.src + off) % 1024) << 20)
                            | (((c.dst + off) % 1024) << 10) | (c.sf << 9) | (c.df << 8) | ch;
            3:       return (32'd3 << 30) | ((c.group % 32) << 24) | ((c.fetch >> 4) % 32'h0100_0000);
            default: return (32'd3 << 30) | (32'd1 << 29) | ((c.group % 32) << 24) | ((c.sub % 16) << 20);
        endcase
    endfunction

    // ---------------- scoreboard / compare process ----------------
    cmd_t        cur;
    logic [31:0] exp_q[$];
    int unsigned err_q[$];
    int unsigned hs_seen = 0;
    int unsigned e_m;
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    bit          rand_done = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            err_q.delete();
            hs_seen = 0;
            held_v  = 1'b0;
        end else begin
            check("inst_count", inst_count, hs_seen);
            if (held_v && inst_valid) check("stall_hold", inst_data, held_d);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_word: actual=0x%08h expected=none", inst_data);
                end else begin
                    check("word", inst_data, exp_q.pop_front());
                end
                hs_seen++;
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_err: actual=%0d expected=none", err_code);
                end else begin
                    check("err_code", 32'(err_code), err_q.pop_front());
                end
            end
            held_v = inst_valid && !inst_ready;
            held_d = inst_data;
            if (cmd_valid && cmd_ready) begin
                e_m = ref_err(cur);
                if (e_m != 0) err_q.push_back(e_m);
                else for (int k = 0; k < int'(ref_nwords(cur)); k++) exp_q.push_back(ref_word(cur, k));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input cmd_t c, output int waits);
        cur            = c;
        cmd_op         = 3'(c.op);
        cmd_rf_addr    = 10'(c.rf);
        cmd_sdram_addr = c.sdram;
        cmd_src_addr   = 10'(c.src);
        cmd_dst_addr   = 10'(c.dst);
        cmd_src_freeze = c.sf[0];
        cmd_dst_freeze = c.df[0];
        cmd_line_num   = 16'(c.lines);
        cmd_eu_group   = 5'(c.group);
        cmd_eu_sub     = 4'(c.sub);
        cmd_fetch_addr = c.fetch;
        cmd_valid      = 1'b1;
        waits          = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!cmd_ready && waits < 2000);
        check("accept_timeout", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op    = ($urandom_range(0, 99) < 90) ? $urandom_range(0, 4) : $urandom_range(5, 7);
        c.lines = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 700);
        c.rf    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 200);
        c.sdram = ((($urandom_range(0, 9) == 0) ? $urandom_range(0, 32767) : 32'h1000) << 17)
                | ($urandom_range(0, 7000) << 4)
                | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0);
        c.src   = $urandom_range(0, 1023) >> $urandom_range(0, 2);
        c.dst   = $urandom_range(0, 1023) >> $urandom_range(0, 2);
        c.sf    = $urandom_range(0, 1);
        c.df    = $urandom_range(0, 1);
        c.group = $urandom_range(0, 31);
        c.sub   = $urandom_range(0, 15);
        c.fetch = (($urandom_range(0, 7) == 0) ? ($urandom_range(1, 15) << 28) : 0)
                | ($urandom_range(0, 32'h00FF_FFFF) << 4)
                | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0);
        return c;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        cmd_t c1, c2, cf, ce, c;
        cmd_t errs[4];
        int   codes[4];
        int   w, lines, gran;

        c1 = mk(0, 5, 32'h2000_0120, 0, 0, 0, 0, 8, 0, 0, 0);
        c2 = mk(2, 0, 0, 32'h010, 32'h100, 1, 0, 600, 0, 0, 0);
        cf = mk(3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h0000_1230);
        ce = mk(4, 0, 0, 0, 0, 0, 0, 0, 3, 5, 0);
        errs[0] = mk(0, 5, 32'h2000_0128, 0, 0, 0, 0, 8, 0, 0, 0);     codes[0] = 3;
        errs[1] = mk(0, 5, 32'h2000_0120, 0, 0, 0, 0, 0, 0, 0, 0);     codes[1] = 2;
        errs[2] = mk(2, 0, 0, 0, 32'h3FE, 0, 0, 90, 0, 0, 0);          codes[2] = 4;
        errs[3] = mk(6, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0);                 codes[3] = 1;

        // Pin the reference model with hand-computed words.
        check("pin_load",  ref_word(c1, 0), 32'h00A0_1208);
        check("pin_move0", ref_word(c2, 0), 32'h8104_02FF);
        check("pin_move1", ref_word(c2, 1), 32'h90F7_FEFF);
        check("pin_move2", ref_word(c2, 2), 32'hA0EB_FA5A);
        check("pin_fetch", ref_word(cf, 0), 32'hC300_0123);
        check("pin_exec",  ref_word(ce, 0), 32'hE350_0000);
        for (int i = 0; i < 4; i++) check("pin_err", ref_err(errs[i]), codes[i]);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_inst_data",  inst_data, 0);
        check("rst_err_valid",  32'(err_valid), 0);
        check("rst_err_code",   32'(err_code), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_inst_count", inst_count, 0);
        check("rst_cmd_ready",  32'(cmd_ready), 1);
        @(posedge clk);
        #1;

        // Single-word LOAD.
        send(c1, w);
        @(negedge clk);
        check("load_valid", 32'(inst_valid), 1);
        check("load_word",  inst_data, 32'h00A0_1208);
        check("load_busy",  32'(busy), 1);
        @(negedge clk);
        check("load_done_valid", 32'(inst_valid), 0);
        check("load_done_busy",  32'(busy), 0);
        check("load_done_count", inst_count, 1);
        check("load_done_ready", 32'(cmd_ready), 1);
        wait_idle();

        // Split MOVE with a three-cycle stall on the second word.
        pulse_reset();
        send(c2, w);
        @(posedge clk);
        #1 inst_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("move_stall_valid", 32'(inst_valid), 1);
            check("move_stall_word",  inst_data, 32'h90F7_FEFF);
        end
        @(posedge clk);
        #1 inst_ready = 1'b1;
        wait_idle();
        check("move_count", inst_count, 3);

        // FETCH then EXEC.
        send(cf, w);
        @(negedge clk);
        check("fetch_word", inst_data, 32'hC300_0123);
        wait_idle();
        send(ce, w);
        @(negedge clk);
        check("exec_word", inst_data, 32'hE350_0000);
        wait_idle();

        // Rejected commands.
        for (int i = 0; i < 4; i++) begin
            send(errs[i], w);
            @(negedge clk);
            check("err_pulse",      32'(err_valid), 1);
            check("err_code_now",   32'(err_code), codes[i]);
            check("err_no_inst",    32'(inst_valid), 0);
            check("err_cmd_ready",  32'(cmd_ready), 1);
            @(negedge clk);
            check("err_pulse_end",  32'(err_valid), 0);
            check("err_code_held",  32'(err_code), codes[i]);
            @(posedge clk);
            #1;
        end

        // Reset while the second MOVE word is pending.
        send(c2, w);
        @(posedge clk);
        #1 inst_ready = 1'b0;
        @(negedge clk);
        check("rst_mid_pending", inst_data, 32'h90F7_FEFF);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(inst_valid), 0);
        check("rst_mid_busy",  32'(busy), 0);
        check("rst_mid_count", inst_count, 0);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        repeat (5) begin
            @(negedge clk);
            check("rst_mid_quiet", 32'(inst_valid), 0);
        end
        @(posedge clk);
        #1;
        send(c1, w);
        @(negedge clk);
        check("post_rst_load", inst_data, 32'h00A0_1208);
        wait_idle();

        // Back-to-back random legal LOADs with cmd_valid held high.
        for (int i = 0; i < 100; i++) begin
            lines = $urandom_range(1, 255);
            gran  = $urandom_range(0, 8192 - lines);
            c     = mk(0, $urandom_range(0, 512 - lines), 32'h2000_0000 | (gran << 4),
                       0, 0, 0, 0, lines, 0, 0, 0);
            send(c, w);
            if (i > 0) check("b2b_gap", w, 2);
        end
        wait_idle();

        // Random mixed commands with random downstream backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(rand_cmd(), w);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 inst_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        inst_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        check("words_left", 32'(exp_q.size()), 0);
        check("errs_left",  32'(err_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_encode.md
Name: inst_encode

Overview:
- Command-to-instruction encoder: accepts typed NPU commands (load, store, move, fetch, exec) on a valid/ready port and emits 32-bit instruction words in the control-unit ISA on a second valid/ready port.
- Splits long load/store/move transfers into several instructions of at most 255 lines each, advancing the addresses for each chunk.
- Validates every field against the encoding limits and rejects illegal commands with an error code.
- Sits on the host/sequencer side and feeds the instruction memory or queue that the control unit decodes.

Parameters:
RF_ADDR_W, 10, register-file line address width; the move fields are this wide, the load/store RF field is 9 bits.
SDRAM_OFFSET, 15'h1000, required value of SDRAM byte-address bits [31:17] for load/store.
SDRAM_GRANULES_PER_LINE, 1, 16-byte SDRAM granules advanced per transferred line when splitting.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  encoder accepts the command this cycle
cmd_op  in  3  0=LOAD 1=STORE 2=MOVE 3=FETCH 4=EXEC; 5-7 illegal
cmd_rf_addr  in  RF_ADDR_W  load/store RF start line
cmd_sdram_addr  in  32  load/store SDRAM byte address
cmd_src_addr  in  RF_ADDR_W  move source line
cmd_dst_addr  in  RF_ADDR_W  move destination line
cmd_src_freeze  in  1  move source freeze flag
cmd_dst_freeze  in  1  move destination freeze flag
cmd_line_num  in  16  total lines, 1..65535
cmd_eu_group  in  5  execution-unit group index
cmd_eu_sub  in  4  execution-unit sub index (EXEC only)
cmd_fetch_addr  in  32  fetch byte address
inst_valid  out  1  instruction word valid
inst_ready  in  1  downstream accepts the word
inst_data  out  32  encoded instruction
err_valid  out  1  one-cycle pulse: command rejected
err_code  out  3  0=none 1=BAD_OP 2=ZERO_LINES 3=ALIGN 4=RANGE; held until the next error
busy  out  1  high while not IDLE
inst_count  out  32  words handshaken since reset; wraps

Behaviour:
- Encodings:
  - LOAD/STORE = {op2, rf[8:0], sdram[16:4], lines8}.
  - MOVE = {2'b10, src, dst, src_freeze, dst_freeze, lines8}.
  - FETCH = {2'b11, 0, group, fetch[27:4]}.
  - EXEC = {2'b11, 1, group, sub, 20'b0}.
- Reset: state IDLE; inst_valid=0, inst_data=0, err_valid=0, err_code=0, busy=0, inst_count=0, cmd_ready=1 the cycle after reset deasserts. Reset mid-split abandons the remaining chunks.
- FSM states are IDLE and EMIT.
  - cmd_ready=1 only in IDLE.
  - On cmd_valid&&cmd_ready the checks run combinationally in the same cycle.
- If a command passes its checks:
  - Go to EMIT.
  - The first word is registered, so inst_valid=1 in the cycle after accept.
  - Latch the remaining line count, the current addresses and the flags.
- If a command fails its checks:
  - Drop it and stay in IDLE.
  - err_valid pulses in the cycle after accept and err_code is updated.
  - No word is emitted.
  - When several checks fail, the priority is BAD_OP > ZERO_LINES > ALIGN > RANGE.
- Checks:
  - LOAD/STORE: sdram[3:0]==0, otherwise ALIGN. sdram[31:17]==SDRAM_OFFSET, otherwise RANGE. rf+lines ≤ 512, otherwise RANGE. sdram[16:4]+lines*SDRAM_GRANULES_PER_LINE ≤ 8192, otherwise RANGE.
  - MOVE: src+lines ≤ 2^RF_ADDR_W and dst+lines ≤ 2^RF_ADDR_W, otherwise RANGE.
  - FETCH: fetch[3:0]==0, otherwise ALIGN. fetch[31:28]==0, otherwise RANGE.
  - cmd_line_num is ignored for FETCH and EXEC.
- Splitting rule: chunk = min(remaining, 255). A lines8 field of 0 is never emitted.
- EMIT:
  - inst_data is held stable while inst_valid && !inst_ready.
  - On handshake, inst_count increments and remaining -= chunk.
  - If remaining > 0, the next word appears in the next cycle (one word per cycle under continuous ready). Addresses advance: rf/src/dst += chunk; SDRAM granule += chunk*SDRAM_GRANULES_PER_LINE.
  - If remaining == 0, inst_valid=0 and the FSM returns to IDLE. cmd_ready=1 in that next cycle, so single-word commands sustain one word per two cycles.
- Freeze flags and the op are replicated on every chunk.
- Address arithmetic is done at full width plus one bit, so the range checks cannot wrap.

Decomposition:
- Package npu_isa_pkg: op_t (2-bit ISA op), cmd_op_t (3-bit), err_code_t, field MSB/LSB localparams, LINE_MAX=255. The decoder side shares this package.
- One combinational sub-module, inst_field_pack: it takes op plus the current fields and chunk and produces the 32-bit word. The FSM, the checks and the counters stay in inst_encode.

Test Plan:
1. LOAD rf=0x005, sdram=0x2000_0120, lines=8 -> one word 0x00A0_1208 one cycle after accept; inst_count=1; busy falls after the handshake.
2. MOVE src=0x010, dst=0x100, src_freeze=1, lines=600, inst_ready low for 3 cycles on the second word -> words 0x8104_02FF, 0x90F7_FEFF, 0xA0EB_FA5A. The second word is held stable during the stall. inst_count=3.
3. FETCH group=3, fetch=0x0000_1230 -> 0xC300_0123. Then EXEC group=3, sub=5 -> 0xE350_0000.
4. Error commands -> err_valid pulse each, no inst_valid, cmd_ready stays high:
   - LOAD sdram=0x2000_0128 -> err_code=3.
   - LOAD lines=0 -> err_code=2.
   - MOVE dst=0x3FE, lines=90 -> err_code=4.
   - op=6 -> err_code=1.
5. rst asserted while the second word of scenario 2 is pending -> next cycle inst_valid=0, busy=0, inst_count=0, and no further words. A fresh LOAD then encodes correctly.
6. Back-to-back LOADs with cmd_valid held high and inst_ready=1 -> accepts every 2 cycles, words in order, no duplicates or losses over 100 random legal commands checked against a reference encoder.
